// File: rtl/ch_arbiter_if.sv
// Bundle of raw request buttons and grant/channel outputs for ch_arbiter.
// The design side uses the slave modport; the driver/observer uses master.
interface ch_arbiter_if;
    logic a_up;
    logic a_down;
    logic b_up;
    logic b_down;
    logic gnt_a;
    logic gnt_b;
    logic busy;
    logic ch_out;

    modport master (
        output a_up, a_down, b_up, b_down,
        input  gnt_a, gnt_b, busy, ch_out
    );

    modport slave (
        input  a_up, a_down, b_up, b_down,
        output gnt_a, gnt_b, busy, ch_out
    );
endinterface

// File: rtl/ch_arbiter.sv
// Two-requester channel arbiter with input synchronisers, minimum grant hold
// time and round-robin tie breaking.
module ch_arbiter #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    ch_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    logic [3:0]       raw_s;
    logic [3:0]       sync_r [SYNC_STAGES];
    logic             req_a_s;
    logic             req_b_s;
    logic             hold_done_s;
    logic             enter_s;
    state_t           next_state_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             last_r;
    logic             gnt_a_r;
    logic             gnt_b_r;
    logic             busy_r;
    logic             ch_out_r;

    assign raw_s = {bus.b_down, bus.b_up, bus.a_down, bus.a_up};

    // Synchroniser chain: stage 0 samples the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_r[i] <= 4'b0000;
            end
        end else begin
            sync_r[0] <= raw_s;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign req_a_s     = sync_r[SYNC_STAGES-1][0] | sync_r[SYNC_STAGES-1][1];
    assign req_b_s     = sync_r[SYNC_STAGES-1][2] | sync_r[SYNC_STAGES-1][3];
    assign hold_done_s = (cnt_r == HOLD_LAST);

    // Next-state decision; a grant is never released before the hold expires.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_a_s && (!req_b_s || (last_r == LAST_B))) begin
                    next_state_s = GRANT_A;
                end else if (req_b_s) begin
                    next_state_s = GRANT_B;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT_A: begin
                if (!hold_done_s) begin
                    next_state_s = GRANT_A;
                end else if (req_b_s) begin
                    next_state_s = GRANT_B;
                end else if (req_a_s) begin
                    next_state_s = GRANT_A;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT_B: begin
                if (!hold_done_s) begin
                    next_state_s = GRANT_B;
                end else if (req_a_s) begin
                    next_state_s = GRANT_A;
                end else if (req_b_s) begin
                    next_state_s = GRANT_B;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign enter_s = ((next_state_s == GRANT_A) && (state_r != GRANT_A)) ||
                     ((next_state_s == GRANT_B) && (state_r != GRANT_B));

    // State, hold counter, last-granted pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            last_r   <= LAST_B;
            gnt_a_r  <= 1'b0;
            gnt_b_r  <= 1'b0;
            busy_r   <= 1'b0;
            ch_out_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (enter_s) begin
                cnt_r  <= '0;
                last_r <= (next_state_s == GRANT_B) ? LAST_B : LAST_A;
            end else if ((next_state_s != IDLE) && !hold_done_s) begin
                cnt_r  <= cnt_r + CNT_W'(1);
                last_r <= last_r;
            end else begin
                cnt_r  <= cnt_r;
                last_r <= last_r;
            end
            gnt_a_r  <= (next_state_s == GRANT_A);
            gnt_b_r  <= (next_state_s == GRANT_B);
            busy_r   <= (next_state_s != IDLE);
            // Channel follows only the requester that owns the next grant cycle.
            ch_out_r <= ((next_state_s == GRANT_A) && req_a_s) ||
                        ((next_state_s == GRANT_B) && req_b_s);
        end
    end

    assign bus.gnt_a  = gnt_a_r;
    assign bus.gnt_b  = gnt_b_r;
    assign bus.busy   = busy_r;
    assign bus.ch_out = ch_out_r;

endmodule
